// File: rtl/lsu_dmem.sv
// MEM-stage data memory: byte-lane synchronous RAM behind a valid/ready port.
// Word-crossing accesses are split into two RAM cycles or faulted, by MISALIGN_MODE.

module lsu_dmem_lane #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_wdata,
   output logic [7:0]        o_rdata
);
   logic [7:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_addr];
   end
endmodule

module lsu_dmem #(
   parameter int ADDR_W        = 14,
   parameter int MISALIGN_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);
   localparam int NUM_LANES = 4;

   typedef enum logic {S_IDLE, S_SPLIT} state_t;

   // Request context carried into the SPLIT cycle and the response cycle.
   typedef struct packed {
      logic [ADDR_W-1:0]             word;
      logic [1:0]                    off;
      logic [2:0]                    fin;
      logic [1:0]                    size;
      logic                          uns;
      logic                          we;
      logic                          ld;
      logic                          split;
      logic [NUM_LANES-1:0][7:0]     wrot;
   } req_ctx_t;

   state_t   r_state, w_state_nxt;
   req_ctx_t r_req;
   logic     r_resp_valid, r_resp_fault;
   logic [31:0] r_hold;
   logic [NUM_LANES-1:0][7:0] r_lo;

   logic [1:0]  w_off;
   logic [1:0]  w_size;
   logic [ADDR_W-1:0] w_word;
   logic [2:0]  w_nbytes, w_fin;
   logic        w_cross, w_misal, w_fault, w_split, w_acc, w_sec;
   logic [NUM_LANES-1:0][7:0] w_wbytes, w_wrot, w_q, w_comb, w_gath;
   logic [NUM_LANES-1:0][7:0] w_ram_wdata;
   logic [NUM_LANES-1:0]      w_mask1, w_mask2, w_ram_we;
   logic        w_ram_re;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [31:0] w_ext;
   logic        w_unused;

   assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};

   assign w_off    = req_addr[1:0];
   assign w_size   = req_funct3[1:0];
   assign w_word   = req_addr[ADDR_W+1:2];
   assign w_wbytes = req_wdata;

   always_comb begin
      case (w_size)
         2'b00:   w_nbytes = 3'd1;
         2'b01:   w_nbytes = 3'd2;
         default: w_nbytes = 3'd4;
      endcase
   end

   assign w_fin   = {1'b0, w_off} + w_nbytes;
   assign w_cross = w_fin > 3'd4;
   assign w_misal = ((w_size == 2'b01) & w_off[0]) | ((w_size == 2'b10) & (w_off != 2'b00));
   assign w_fault = (w_size == 2'b11) | (req_we & req_funct3[2]) |
                    ((MISALIGN_MODE != 0) & w_misal);
   assign w_split = w_cross & ~w_fault & (MISALIGN_MODE == 0);

   assign req_ready = (r_state == S_IDLE) & ~rst;
   assign w_acc     = req_valid & req_ready;
   assign w_sec     = (r_state == S_SPLIT) & ~rst;

   // First access covers lanes off..min(off+n,4)-1, second covers 0..off+n-5.
   always_comb begin
      w_mask1 = '0;
      w_mask2 = '0;
      w_wrot  = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         w_mask1[l] = (3'(l) >= {1'b0, w_off}) && (3'(l) < w_fin);
         w_mask2[l] = (3'(l) + 3'd4) < r_req.fin;
         w_wrot[l]  = w_wbytes[2'(l) - w_off];
      end
   end

   assign w_ram_addr  = w_sec ? (r_req.word + ADDR_W'(1)) : w_word;
   assign w_ram_wdata = w_sec ? r_req.wrot : w_wrot;
   assign w_ram_re    = (w_acc & ~req_we & ~w_fault) | (w_sec & ~r_req.we);

   always_comb begin
      w_ram_we = '0;
      for (int l = 0; l < NUM_LANES; l++)
         w_ram_we[l] = (w_acc & req_we & ~w_fault & w_mask1[l]) |
                       (w_sec & r_req.we & w_mask2[l]);
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      lsu_dmem_lane #(.ADDR_W(ADDR_W)) u_lane (
         .clk     (clk),
         .i_we    (w_ram_we[l]),
         .i_re    (w_ram_re),
         .i_addr  (w_ram_addr),
         .i_wdata (w_ram_wdata[l]),
         .o_rdata (w_q[l])
      );
   end

   // Split loads: upper lanes come from the held first read, lower from the second.
   always_comb begin
      w_comb = '0;
      w_gath = '0;
      for (int l = 0; l < NUM_LANES; l++)
         w_comb[l] = (r_req.split && (2'(l) >= r_req.off)) ? r_lo[l] : w_q[l];
      for (int i = 0; i < NUM_LANES; i++)
         w_gath[i] = w_comb[2'(i) + r_req.off];
   end

   always_comb begin
      w_ext = '0;
      if (r_req.ld) begin
         case (r_req.size)
            2'b00:   w_ext = {{24{~r_req.uns & w_gath[0][7]}}, w_gath[0]};
            2'b01:   w_ext = {{16{~r_req.uns & w_gath[1][7]}}, w_gath[1], w_gath[0]};
            default: w_ext = w_gath;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_acc && w_split) w_state_nxt = S_SPLIT;
         S_SPLIT: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_resp_valid <= 1'b0;
         r_resp_fault <= 1'b0;
         r_hold       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_resp_valid <= (w_acc & ~w_split) | w_sec;
         if (w_acc && !w_split) r_resp_fault <= w_fault;
         else if (w_sec)        r_resp_fault <= 1'b0;
         if (r_resp_valid)      r_hold <= w_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_req.word  <= w_word;
         r_req.off   <= w_off;
         r_req.fin   <= w_fin;
         r_req.size  <= w_size;
         r_req.uns   <= req_funct3[2];
         r_req.we    <= req_we;
         r_req.ld    <= ~req_we & ~w_fault;
         r_req.split <= w_split;
         r_req.wrot  <= w_wrot;
      end
      if (r_state == S_SPLIT) r_lo <= w_q;
   end

   assign resp_valid = r_resp_valid;
   assign resp_fault = r_resp_fault;
   // Live data in the response cycle, latched copy afterwards.
   assign resp_rdata = r_resp_valid ? w_ext : r_hold;
endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: three instances (split mode, 16-word wrap, fault mode)
// share one request bus; each scenario task checks the instance it targets.
module tb_lsu_dmem;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   logic        rdy [3];
   logic        rv  [3];
   logic        fo  [3];
   logic [31:0] rdo [3];

   int          checks = 0;
   int          failures = 0;
   int          lat [3];
   logic [31:0] rd  [3];
   logic        fl  [3];
   int          rdy_low;

   always #5 clk = ~clk;

   lsu_dmem #(.ADDR_W(14), .MISALIGN_MODE(0)) u_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv[0]), .resp_rdata(rdo[0]), .resp_fault(fo[0]));
   lsu_dmem #(.ADDR_W(4), .MISALIGN_MODE(0)) u_w (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv[1]), .resp_rdata(rdo[1]), .resp_fault(fo[1]));
   lsu_dmem #(.ADDR_W(14), .MISALIGN_MODE(1)) u_m (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv[2]), .resp_rdata(rdo[2]), .resp_fault(fo[2]));

   // One request, then a 4-cycle window recording each instance's first response.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0; req_we = 1'b0;
      rdy_low = 0;
      for (int k = 0; k < 3; k++) begin lat[k] = 0; rd[k] = 'x; fl[k] = 1'bx; end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (!rdy[0]) rdy_low++;
         for (int k = 0; k < 3; k++)
            if (rv[k] && lat[k] == 0) begin lat[k] = c; rd[k] = rdo[k]; fl[k] = fo[k]; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++; if (rv[k] !== 1'b0) begin failures++; $display("FAIL reset_valid dut%0d got=%b exp=0", k, rv[k]); end
         checks++; if (fo[k] !== 1'b0) begin failures++; $display("FAIL reset_fault dut%0d got=%b exp=0", k, fo[k]); end
         checks++; if (rdo[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata dut%0d got=%h exp=0", k, rdo[k]); end
         checks++; if (rdy[k] !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst dut%0d got=%b exp=0", k, rdy[k]); end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++; if (rdy[k] !== 1'b1) begin failures++; $display("FAIL reset_ready_after dut%0d got=%b exp=1", k, rdy[k]); end
      end
   endtask

   task automatic test_aligned();
      xact(1'b1, 3'b010, 32'h10, 32'h8000_00FF);
      checks++; if (lat[0] !== 1) begin failures++; $display("FAIL sw10_lat got=%0d exp=1", lat[0]); end
      checks++; if (rd[0] !== 32'h0) begin failures++; $display("FAIL sw10_rdata got=%h exp=0", rd[0]); end
      checks++; if (fl[0] !== 1'b0) begin failures++; $display("FAIL sw10_fault got=%b exp=0", fl[0]); end
      xact(1'b0, 3'b010, 32'h10, 32'h0);
      checks++; if (lat[0] !== 1 || rd[0] !== 32'h8000_00FF) begin failures++; $display("FAIL lw10 lat=%0d got=%h exp=800000ff", lat[0], rd[0]); end
      xact(1'b0, 3'b000, 32'h10, 32'h0);
      checks++; if (rd[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lb10 got=%h exp=ffffffff", rd[0]); end
      xact(1'b0, 3'b100, 32'h13, 32'h0);
      checks++; if (rd[0] !== 32'h0000_0080) begin failures++; $display("FAIL lbu13 got=%h exp=00000080", rd[0]); end
      xact(1'b0, 3'b000, 32'h13, 32'h0);
      checks++; if (rd[0] !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb13 got=%h exp=ffffff80", rd[0]); end
      xact(1'b0, 3'b001, 32'h12, 32'h0);
      checks++; if (rd[0] !== 32'hFFFF_8000) begin failures++; $display("FAIL lh12 got=%h exp=ffff8000", rd[0]); end
      xact(1'b0, 3'b101, 32'h12, 32'h0);
      checks++; if (rd[0] !== 32'h0000_8000) begin failures++; $display("FAIL lhu12 got=%h exp=00008000", rd[0]); end
   endtask

   task automatic test_lanes();
      xact(1'b1, 3'b010, 32'h20, 32'h1122_3344);
      xact(1'b1, 3'b000, 32'h21, 32'h5555_55AA);
      xact(1'b1, 3'b001, 32'h22, 32'h7777_BEEF);
      xact(1'b0, 3'b010, 32'h20, 32'h0);
      checks++; if (rd[0] !== 32'hBEEF_AA44) begin failures++; $display("FAIL lanes_lw20 got=%h exp=beefaa44", rd[0]); end
   endtask

   task automatic test_split();
      xact(1'b1, 3'b010, 32'h33, 32'hDDCC_BBAA);
      checks++; if (lat[0] !== 2) begin failures++; $display("FAIL split_sw_lat got=%0d exp=2", lat[0]); end
      checks++; if (rdy_low !== 1) begin failures++; $display("FAIL split_ready_low got=%0d exp=1", rdy_low); end
      checks++; if (lat[2] !== 1 || fl[2] !== 1'b1) begin failures++; $display("FAIL mode1_sw33_fault lat=%0d got=%b exp=1", lat[2], fl[2]); end
      xact(1'b0, 3'b010, 32'h33, 32'h0);
      checks++; if (lat[0] !== 2 || rd[0] !== 32'hDDCC_BBAA) begin failures++; $display("FAIL split_lw33 lat=%0d got=%h exp=ddccbbaa", lat[0], rd[0]); end
      checks++; if (rdo[0] !== 32'hDDCC_BBAA) begin failures++; $display("FAIL split_hold got=%h exp=ddccbbaa", rdo[0]); end
      xact(1'b0, 3'b010, 32'h30, 32'h0);
      checks++; if (lat[0] !== 1 || rd[0][31:24] !== 8'hAA) begin failures++; $display("FAIL lw30_top lat=%0d got=%h exp=aa", lat[0], rd[0][31:24]); end
      xact(1'b0, 3'b100, 32'h36, 32'h0);
      checks++; if (rd[0] !== 32'h0000_00DD) begin failures++; $display("FAIL lbu36 got=%h exp=000000dd", rd[0]); end
      xact(1'b0, 3'b001, 32'h33, 32'h0);
      checks++; if (lat[0] !== 2 || rd[0] !== 32'hFFFF_BBAA) begin failures++; $display("FAIL split_lh33 lat=%0d got=%h exp=ffffbbaa", lat[0], rd[0]); end
      xact(1'b0, 3'b101, 32'h33, 32'h0);
      checks++; if (rd[0] !== 32'h0000_BBAA) begin failures++; $display("FAIL split_lhu33 got=%h exp=0000bbaa", rd[0]); end
      xact(1'b1, 3'b010, 32'h51, 32'h0403_0201);
      xact(1'b0, 3'b010, 32'h51, 32'h0);
      checks++; if (rd[0] !== 32'h0403_0201) begin failures++; $display("FAIL split_lw51 got=%h exp=04030201", rd[0]); end
      xact(1'b0, 3'b010, 32'h50, 32'h0);
      checks++; if (rd[0][31:8] !== 24'h030201) begin failures++; $display("FAIL lw50_upper got=%h exp=030201", rd[0][31:8]); end
   endtask

   task automatic test_faults();
      xact(1'b1, 3'b010, 32'h60, 32'hCAFE_F00D);
      xact(1'b0, 3'b010, 32'h60, 32'h0);
      checks++; if (rd[0] !== 32'hCAFE_F00D) begin failures++; $display("FAIL fault_pre_lw60 got=%h exp=cafef00d", rd[0]); end
      xact(1'b0, 3'b011, 32'h60, 32'h0);
      checks++; if (lat[0] !== 1 || fl[0] !== 1'b1) begin failures++; $display("FAIL f3_011_ld lat=%0d fault=%b exp=1", lat[0], fl[0]); end
      checks++; if (rd[0] !== 32'h0) begin failures++; $display("FAIL f3_011_ld_rdata got=%h exp=0", rd[0]); end
      xact(1'b1, 3'b011, 32'h60, 32'hFFFF_FFFF);
      checks++; if (fl[0] !== 1'b1) begin failures++; $display("FAIL f3_011_st fault=%b exp=1", fl[0]); end
      xact(1'b1, 3'b100, 32'h60, 32'h0000_0011);
      checks++; if (fl[0] !== 1'b1 || rd[0] !== 32'h0) begin failures++; $display("FAIL sb_unsigned fault=%b rdata=%h exp=1/0", fl[0], rd[0]); end
      xact(1'b0, 3'b010, 32'h60, 32'h0);
      checks++; if (fl[0] !== 1'b0 || rd[0] !== 32'hCAFE_F00D) begin failures++; $display("FAIL fault_post_lw60 fault=%b got=%h exp=cafef00d", fl[0], rd[0]); end
      checks++; if (fl[2] !== 1'b0 || rd[2] !== 32'hCAFE_F00D) begin failures++; $display("FAIL mode1_lw60 fault=%b got=%h exp=cafef00d", fl[2], rd[2]); end
      xact(1'b0, 3'b010, 32'h02, 32'h0);
      checks++; if (lat[2] !== 1 || fl[2] !== 1'b1 || rd[2] !== 32'h0) begin failures++; $display("FAIL mode1_lw02 lat=%0d fault=%b rdata=%h exp=1/1/0", lat[2], fl[2], rd[2]); end
      xact(1'b0, 3'b001, 32'h61, 32'h0);
      checks++; if (fl[2] !== 1'b1) begin failures++; $display("FAIL mode1_lh61 fault=%b exp=1", fl[2]); end
      checks++; if (lat[0] !== 1 || rd[0] !== 32'hFFFF_FEF0) begin failures++; $display("FAIL mode0_lh61 lat=%0d got=%h exp=fffffef0", lat[0], rd[0]); end
      xact(1'b1, 3'b001, 32'h61, 32'h0000_5555);
      checks++; if (fl[2] !== 1'b1) begin failures++; $display("FAIL mode1_sh61 fault=%b exp=1", fl[2]); end
      xact(1'b0, 3'b010, 32'h60, 32'h0);
      checks++; if (rd[2] !== 32'hCAFE_F00D) begin failures++; $display("FAIL mode1_unchanged got=%h exp=cafef00d", rd[2]); end
      checks++; if (rd[0] !== 32'hCA55_550D) begin failures++; $display("FAIL mode0_sh61 got=%h exp=ca55550d", rd[0]); end
   endtask

   task automatic test_wrap();
      xact(1'b1, 3'b001, 32'h3F, 32'h0000_1234);
      checks++; if (lat[1] !== 2) begin failures++; $display("FAIL wrap_sh_lat got=%0d exp=2", lat[1]); end
      xact(1'b0, 3'b100, 32'h00, 32'h0);
      checks++; if (rd[1] !== 32'h0000_0012) begin failures++; $display("FAIL wrap_lbu00 got=%h exp=00000012", rd[1]); end
      xact(1'b0, 3'b100, 32'h3F, 32'h0);
      checks++; if (rd[1] !== 32'h0000_0034) begin failures++; $display("FAIL wrap_lbu3f got=%h exp=00000034", rd[1]); end
      xact(1'b0, 3'b101, 32'h3F, 32'h0);
      checks++; if (lat[1] !== 2 || rd[1] !== 32'h0000_1234) begin failures++; $display("FAIL wrap_lhu3f lat=%0d got=%h exp=00001234", lat[1], rd[1]); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h70; req_wdata = 32'h5A5A_1234;
      @(negedge clk);
      checks++; if (rv[0] !== 1'b1 || rdo[0] !== 32'h0) begin failures++; $display("FAIL b2b_store_resp valid=%b rdata=%h exp=1/0", rv[0], rdo[0]); end
      checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", rdy[0]); end
      req_we = 1'b0; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (rv[0] !== 1'b1 || rdo[0] !== 32'h5A5A_1234) begin failures++; $display("FAIL b2b_load valid=%b got=%h exp=5a5a1234", rv[0], rdo[0]); end
      @(negedge clk);
      checks++; if (rv[0] !== 1'b0 || rdo[0] !== 32'h5A5A_1234) begin failures++; $display("FAIL b2b_hold valid=%b got=%h exp=0/5a5a1234", rv[0], rdo[0]); end
   endtask

   task automatic test_reset_split();
      xact(1'b1, 3'b010, 32'h40, 32'h0);
      xact(1'b1, 3'b010, 32'h44, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h41; req_wdata = 32'hDDCC_BBAA;
      @(posedge clk);
      #1 req_valid = 1'b0; req_we = 1'b0;
      @(negedge clk);
      checks++; if (rdy[0] !== 1'b0 || rv[0] !== 1'b0) begin failures++; $display("FAIL rsplit_in_split ready=%b valid=%b exp=0/0", rdy[0], rv[0]); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (rv[0] !== 1'b0) begin failures++; $display("FAIL rsplit_no_resp1 got=%b exp=0", rv[0]); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rv[0] !== 1'b0) begin failures++; $display("FAIL rsplit_no_resp2 got=%b exp=0", rv[0]); end
      checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL rsplit_ready got=%b exp=1", rdy[0]); end
      xact(1'b0, 3'b010, 32'h40, 32'h0);
      checks++; if (lat[0] !== 1 || rd[0] !== 32'hCCBB_AA00) begin failures++; $display("FAIL rsplit_lw40 lat=%0d got=%h exp=ccbbaa00", lat[0], rd[0]); end
      xact(1'b0, 3'b010, 32'h44, 32'h0);
      checks++; if (rd[0] !== 32'h0) begin failures++; $display("FAIL rsplit_lw44 got=%h exp=0", rd[0]); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_lanes();
      test_split();
      test_faults();
      test_wrap();
      test_back_to_back();
      test_reset_split();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
